// File: rtl/lane_sum_pipe.sv
// lane_sum_pipe: 2-stage LANES x W-bit adder with running accumulator, beat counter and zero flag.
// Result 2 cycles after acceptance, 1 beat/cycle, holds under out_ready=0; `LANE_SUM_OVF_EN adds sticky out_ovf.
module lane_sum_pipe #(
   parameter int LANES = 4,
   parameter int W     = 8,
   parameter int AW    = 16,
   parameter int CW    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_data,
   input  logic               in_cin,
   input  logic               in_acc,
   input  logic               clr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [AW-1:0]      out_sum,
   output logic               out_zero,
`ifdef LANE_SUM_OVF_EN
   output logic               out_ovf,
`endif
   output logic [CW-1:0]      out_cnt
);

   localparam int NP = LANES / 2;
   localparam int SW = W + $clog2(LANES);

   logic               s1_valid_q, s1_valid_d;
   logic [NP-1:0][W:0] s1_pair_q, s1_pair_d;
   logic               s1_cin_q, s1_cin_d;
   logic               s1_acc_q, s1_acc_d;

   logic [AW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               out_valid_q, out_valid_d;
   logic [AW-1:0]      out_sum_q, out_sum_d;
   logic               out_zero_q, out_zero_d;
   logic [CW-1:0]      out_cnt_q, out_cnt_d;

   logic               s2_ready;
   logic               accept;
   logic               s2_load;
   logic               restart;
   logic [SW-1:0]      beat_sum;
   logic [AW-1:0]      beat_ext;
   logic [AW-1:0]      acc_add;

`ifdef LANE_SUM_OVF_EN
   logic               ovf_q, ovf_d;
   logic               out_ovf_q, out_ovf_d;
   logic               acc_carry;
`endif

   // Handshake: in_ready never looks at in_valid.
   always_comb begin
      s2_ready = !out_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_ready;
      accept   = in_valid && in_ready;
      s2_load  = s1_valid_q && s2_ready;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_pair_d  = s1_pair_q;
      s1_cin_d   = s1_cin_q;
      s1_acc_d   = s1_acc_q;
      if (s2_load) begin
         s1_valid_d = 1'b0;
      end
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_cin_d   = in_cin;
         s1_acc_d   = in_acc;
         for (int k = 0; k < NP; k++) begin
            s1_pair_d[k] = {1'b0, in_data[(2*k)*W +: W]} + {1'b0, in_data[(2*k+1)*W +: W]};
         end
      end
   end

   always_comb begin
      beat_sum = SW'(s1_cin_q);
      for (int k = 0; k < NP; k++) begin
         beat_sum = beat_sum + SW'(s1_pair_q[k]);
      end
      beat_ext = AW'(beat_sum);
      // A clr landing on the same edge as a beat turns that beat into a restart.
      restart  = !s1_acc_q || clr;
`ifdef LANE_SUM_OVF_EN
      {acc_carry, acc_add} = {1'b0, acc_q} + {1'b0, beat_ext};
`else
      acc_add = acc_q + beat_ext;
`endif
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
`ifdef LANE_SUM_OVF_EN
      ovf_d = ovf_q;
`endif
      if (s2_load) begin
         if (restart) begin
            acc_d = beat_ext;
            cnt_d = CW'(1);
`ifdef LANE_SUM_OVF_EN
            ovf_d = 1'b0;
`endif
         end else begin
            acc_d = acc_add;
            cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
`ifdef LANE_SUM_OVF_EN
            ovf_d = ovf_q | acc_carry;
`endif
         end
      end else if (clr) begin
         acc_d = '0;
         cnt_d = '0;
`ifdef LANE_SUM_OVF_EN
         ovf_d = 1'b0;
`endif
      end
   end

   // Output register only moves when a new beat lands, so a stalled result stays put even across clr.
   always_comb begin
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_zero_d  = out_zero_q;
      out_cnt_d   = out_cnt_q;
`ifdef LANE_SUM_OVF_EN
      out_ovf_d   = out_ovf_q;
`endif
      if (s2_load) begin
         out_valid_d = 1'b1;
         out_sum_d   = acc_d;
         out_zero_d  = (acc_d == '0);
         out_cnt_d   = cnt_d;
`ifdef LANE_SUM_OVF_EN
         out_ovf_d   = ovf_d;
`endif
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_pair_q   <= '0;
         s1_cin_q    <= 1'b0;
         s1_acc_q    <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_zero_q  <= 1'b0;
         out_cnt_q   <= '0;
`ifdef LANE_SUM_OVF_EN
         ovf_q       <= 1'b0;
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_pair_q   <= s1_pair_d;
         s1_cin_q    <= s1_cin_d;
         s1_acc_q    <= s1_acc_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_zero_q  <= out_zero_d;
         out_cnt_q   <= out_cnt_d;
`ifdef LANE_SUM_OVF_EN
         ovf_q       <= ovf_d;
         out_ovf_q   <= out_ovf_d;
`endif
      end
   end

   always_comb begin
      out_valid = out_valid_q;
      out_sum   = out_sum_q;
      out_zero  = out_zero_q;
      out_cnt   = out_cnt_q;
`ifdef LANE_SUM_OVF_EN
      out_ovf   = out_ovf_q;
`endif
   end

endmodule

// File: tb/tb_lane_sum_pipe.sv
// Bench for lane_sum_pipe (LANES=4, W=8, AW=16, CW=8): vector table plus scoreboarded corner sequences.
module tb_lane_sum_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_cin;
   logic        in_acc;
   logic        clr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_zero;
   logic [7:0]  out_cnt;
`ifdef LANE_SUM_OVF_EN
   logic        out_ovf;
`endif

   lane_sum_pipe #(.LANES(4), .W(8), .AW(16), .CW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cin    (in_cin),
      .in_acc    (in_acc),
      .clr       (clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_zero  (out_zero),
`ifdef LANE_SUM_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .out_cnt   (out_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sum;
      logic        zero;
      logic [7:0]  cnt;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [7:0]  l0, l1, l2, l3;
      logic        cin;
      logic        acc;
      logic [15:0] sum;
      logic        zero;
      logic [7:0]  cnt;
   } vec_t;

   int    total = 0;
   int    bad   = 0;
   exp_t  sbq[$];
   vec_t  tab[10];

   int    m_acc = 0;
   int    m_cnt = 0;
   bit    m_ovf = 1'b0;
   bit    force_restart = 1'b0;
   bit    use_tab = 1'b0;
   vec_t  tab_cur;

   bit          held_chk = 1'b0;
   logic [15:0] held_sum;
   logic [7:0]  held_cnt;
   logic [15:0] last_sum;
   logic        last_zero;
   logic [7:0]  last_cnt;
   logic        last_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic model_push();
      int   beat;
      int   nx;
      exp_t e;
      beat = int'(in_data[7:0]) + int'(in_data[15:8]) + int'(in_data[23:16]) + int'(in_data[31:24]) + int'(in_cin);
      if (!in_acc || force_restart) begin
         m_acc = beat;
         m_cnt = 1;
         m_ovf = 1'b0;
      end else begin
         nx = m_acc + beat;
         if (nx > 65535) m_ovf = 1'b1;
         m_acc = nx % 65536;
         m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      if (use_tab) begin
         e.sum  = tab_cur.sum;
         e.zero = tab_cur.zero;
         e.cnt  = tab_cur.cnt;
      end else begin
         e.sum  = 16'(m_acc);
         e.zero = (m_acc == 0);
         e.cnt  = 8'(m_cnt);
      end
      e.ovf = m_ovf;
      sbq.push_back(e);
   endtask

   // One cycle: sample just after the falling edge, then wait for the next falling edge.
   task automatic step(output bit acc_ok);
      exp_t e;
      #1;
      acc_ok = in_valid && in_ready;
      if (held_chk) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_sum", out_sum, held_sum);
         chk("hold_cnt", out_cnt, held_cnt);
      end
      if (acc_ok) model_push();
      if (out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got sum %0d want no output", out_sum);
         end else begin
            e = sbq.pop_front();
            chk("out_sum", out_sum, e.sum);
            chk("out_zero", out_zero, e.zero);
            chk("out_cnt", out_cnt, e.cnt);
`ifdef LANE_SUM_OVF_EN
            chk("out_ovf", out_ovf, e.ovf);
            last_ovf = out_ovf;
`endif
            last_sum  = out_sum;
            last_zero = out_zero;
            last_cnt  = out_cnt;
         end
      end
      held_chk = out_valid && !out_ready;
      held_sum = out_sum;
      held_cnt = out_cnt;
      @(negedge clk);
   endtask

   task automatic drive(input logic [7:0] l0, l1, l2, l3, input logic cin, input logic acc);
      in_valid = 1'b1;
      in_data  = {l3, l2, l1, l0};
      in_cin   = cin;
      in_acc   = acc;
   endtask

   task automatic send(input logic [7:0] l0, l1, l2, l3, input logic cin, input logic acc);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      drive(l0, l1, l2, l3, cin, acc);
      while (!ok && n < 50) begin
         step(ok);
         n++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no accept want accept");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      int n;
      n = 0;
      in_valid = 1'b0;
      while (sbq.size() > 0 && n < 100) begin
         step(ok);
         n++;
      end
      chk("drain_empty", sbq.size(), 0);
   endtask

   task automatic set_vec(input int i, input logic [7:0] l0, l1, l2, l3, input logic cin, input logic acc,
                          input logic [15:0] sum, input logic zero, input logic [7:0] cnt);
      tab[i].l0 = l0; tab[i].l1 = l1; tab[i].l2 = l2; tab[i].l3 = l3;
      tab[i].cin = cin; tab[i].acc = acc;
      tab[i].sum = sum; tab[i].zero = zero; tab[i].cnt = cnt;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int lat;
      int acc_n;
      int gaps;
      int n;
      logic [7:0] bp[4];

      set_vec(0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0, 16'd11,   1'b0, 8'd1);
      set_vec(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 16'd1021, 1'b0, 8'd1);
      set_vec(2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0,    1'b1, 8'd1);
      set_vec(3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 16'd1021, 1'b0, 8'd1);
      set_vec(4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd2042, 1'b0, 8'd2);
      set_vec(5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd3063, 1'b0, 8'd3);
      set_vec(6, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 1'b1, 16'd3223, 1'b0, 8'd4);
      set_vec(7, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 16'd3223, 1'b0, 8'd5);
      set_vec(8, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 16'd512,  1'b0, 8'd1);
      set_vec(9, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1, 16'd514,  1'b0, 8'd2);
      bp[0] = 8'h01; bp[1] = 8'h22; bp[2] = 8'h5A; bp[3] = 8'hC3;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; in_acc = 1'b0;
      clr = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_zero", out_zero, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Single beat latency
      drive(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0);
      step(ok);
      chk("first_accept", ok, 1);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         step(ok);
         lat++;
      end
      chk("latency", lat, 2);
      step(ok);
      chk("single_sum", last_sum, 11);
      chk("single_cnt", last_cnt, 1);

      // Vector table, streamed back to back
      use_tab = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tab_cur = tab[i];
         send(tab[i].l0, tab[i].l1, tab[i].l2, tab[i].l3, tab[i].cin, tab[i].acc);
      end
      use_tab = 1'b0;
      drain();

      // Back-pressure: 6 stalled cycles with in_valid held
      out_ready = 1'b0;
      acc_n = 0;
      for (int c = 0; c < 6; c++) begin
         if (acc_n < 4) drive(bp[acc_n], 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
         else in_valid = 1'b0;
         step(ok);
         if (ok) acc_n++;
      end
      chk("bp_accepted", acc_n, 2);
      chk("bp_in_ready", in_ready, 0);
      out_ready = 1'b1;
      gaps = 0;
      n = 0;
      while ((acc_n < 4 || sbq.size() > 0) && n < 50) begin
         if (acc_n < 4) drive(bp[acc_n], 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
         else in_valid = 1'b0;
         if (!out_valid && sbq.size() > 0) gaps++;
         step(ok);
         if (ok) acc_n++;
         n++;
      end
      in_valid = 1'b0;
      chk("bp_all_out", sbq.size(), 0);
      chk("bp_gaps", gaps, 0);
      chk("bp_last_sum", last_sum, 16'hC3);

      // Wrap past 2^16
      send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
      for (int i = 0; i < 64; i++) send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
      drain();
      chk("wrap_sum", last_sum, 829);
      chk("wrap_cnt", last_cnt, 65);
`ifdef LANE_SUM_OVF_EN
      chk("wrap_ovf", last_ovf, 1);
`endif

      // clr on the edge the beat enters stage 2
      force_restart = 1'b1;
      send(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1);
      force_restart = 1'b0;
      clr = 1'b1;
      step(ok);
      clr = 1'b0;
      drain();
      chk("clr_sum", last_sum, 11);
      chk("clr_cnt", last_cnt, 1);
`ifdef LANE_SUM_OVF_EN
      chk("clr_ovf", last_ovf, 0);
`endif

      // clr while a result is stalled: output held, state cleared
      out_ready = 1'b0;
      send(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0);
      step(ok);
      clr = 1'b1;
      step(ok);
      clr = 1'b0;
      chk("clr_stall_valid", out_valid, 1);
      chk("clr_stall_sum", out_sum, 11);
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      out_ready = 1'b1;
      drain();
      send(8'h00, 8'h00, 8'h00, 8'h05, 1'b0, 1'b1);
      drain();
      chk("post_clr_sum", last_sum, 5);
      chk("post_clr_cnt", last_cnt, 1);

      // Counter saturation
      send(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 259; i++) send(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      drain();
      chk("sat_cnt", last_cnt, 255);
      chk("sat_zero", last_zero, 1);

      // Reset with two beats in flight
      send(8'h10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      send(8'h20, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_sum", out_sum, 0);
      chk("midrst_cnt", out_cnt, 0);
      chk("midrst_zero", out_zero, 0);
      sbq.delete();
      held_chk = 1'b0;
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h00, 8'h03, 8'h00, 8'h04, 1'b0, 1'b1);
      drain();
      chk("postrst_sum", last_sum, 7);
      chk("postrst_cnt", last_cnt, 1);

      repeat (3) step(ok);
      chk("final_empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_sum_pipe.md
Name: lane_sum_pipe

Overview:
- Parametrised successor to the single-cycle field adder.
- Sums LANES packed W-bit operands plus a carry-in through a 2-stage valid/ready pipeline.
- Adds a running accumulator with per-beat accumulate/restart control, a beat counter and a registered zero flag.
- Sits between a packed-record producer and a downstream statistics/checksum consumer that may back-pressure.

Parameters:
- LANES, 4, number of W-bit operand lanes; power of 2, at least 2.
- W, 8, lane width in bits.
- AW, 16, accumulator/output width; must be at least W+$clog2(LANES).
- CW, 8, beat-counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  LANES*W  lane i occupies bits [i*W+W-1 : i*W].
- in_cin  in  1  carry-in added to the beat sum.
- in_acc  in  1  1 = add beat to accumulator; 0 = restart accumulator with this beat.
- clr  in  1  synchronous accumulator/counter clear.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  AW  accumulator value after this beat.
- out_zero  out  1  out_sum == 0, registered together with out_sum.
- out_cnt  out  CW  beats in the current accumulation run, saturating.

Behaviour:
- Reset (asynchronous assert): out_valid=0, out_sum=0, out_zero=0, out_cnt=0, accumulator=0, stage-1 valid=0. in_ready=1 after reset.
- Beat acceptance: in_valid && in_ready.
- Stage 1 registers:
  - LANES/2 pairwise sums, each W+1 bits: lane 2k + lane 2k+1.
  - in_cin and in_acc.
- Stage 2:
  - beat sum = sum of the pair sums + cin, W+$clog2(LANES) bits, no overflow possible; zero-extend to AW.
  - If in_acc=1: acc <= acc + beat sum, modulo 2^AW (wraps).
  - If in_acc=0: acc <= beat sum.
  - out_sum <= new acc; out_zero <= (new acc == 0); out_valid <= 1.
- Latency: result valid 2 cycles after acceptance when not stalled. Throughput: 1 beat/cycle.
- Handshake:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready; combinational, no dependency on in_valid.
  - out_valid drops when out_ready=1 and no new beat moves into stage 2.
  - Held outputs stay stable while out_valid && !out_ready.
  - The pipeline holds at most 2 beats; no loss, no duplication, order preserved.
- out_cnt:
  - Loads 1 on a restart beat.
  - Increments on an accumulate beat; saturates at 2^CW-1.
- clr:
  - Sets acc=0 and out_cnt=0 at the next edge; does not flush the pipeline or drop out_valid.
  - clr in the same cycle a beat enters stage 2: that beat behaves as in_acc=0 (acc=beat sum, cnt=1).
- Reset mid-operation discards all in-flight beats immediately.

Optional Feature:
- Macro LANE_SUM_OVF_EN.
- Defined:
  - Adds port out_ovf (out, 1): sticky flag set when an accumulate addition wraps past 2^AW-1, registered with out_sum.
  - Cleared by a restart beat, by clr, and by reset.
- Undefined: port absent; wrap is silent.

Test Plan (LANES=4, W=8, AW=16, CW=8):
- Single beat: lanes 0x01,0x02,0x03,0x04, cin=1, acc=0, out_ready=1 -> out_valid 2 cycles later; out_sum=11, out_zero=0, out_cnt=1.
- Max and zero: all lanes 0xFF, cin=1 -> out_sum=1021. Next beat all lanes 0, cin=0, acc=0 -> out_sum=0, out_zero=1.
- Accumulate run: three beats of 0xFF×4 + cin=1 with acc=0,1,1 -> out_sum 1021, 2042, 3063; out_cnt 1, 2, 3.
- Back-pressure: out_ready=0 for 6 cycles while in_valid held with 4 distinct beats -> in_ready=0 after 2 accepted; out_sum stable; after release, all 4 results arrive in order with no gaps or repeats.
- Wrap/clr: 65 accumulate beats of 1021 -> last out_sum=829, out_ovf=1 when LANE_SUM_OVF_EN is defined. Then clr coincident with a beat of sum 11 and acc=1 -> out_sum=11, out_cnt=1, out_ovf=0.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0, out_sum=0, out_cnt=0 immediately; first post-reset beat with acc=1 yields its own sum.
